// File: rtl/mx_block_packer_if.sv
// Block-in / word-out handshake bundle for mx_block_packer.
// The slave modport is the packer's view and the master modport is the view of whatever drives and drains it.
interface mx_block_packer_if #(
   parameter int bit_width = 6,
   parameter int k         = 32,
   parameter int bus_width = 32
);
   localparam int blk_bits = 8 + k * bit_width;
   localparam int n_words  = (blk_bits + bus_width - 1) / bus_width;
   localparam int cnt_w    = (n_words > 1) ? $clog2(n_words) : 1;

   logic                          i_valid;
   logic                          o_ready;
   logic [k-1:0][bit_width-1:0]   i_mx_vec;
   logic [7:0]                    i_mx_exp;
   logic                          o_valid;
   logic                          i_ready;
   logic [bus_width-1:0]          o_data;
   logic                          o_last;
   logic [cnt_w-1:0]              o_word_idx;

   modport slave (
      input  i_valid, i_mx_vec, i_mx_exp, i_ready,
      output o_ready, o_valid, o_data, o_last, o_word_idx
   );

   modport master (
      output i_valid, i_mx_vec, i_mx_exp, i_ready,
      input  o_ready, o_valid, o_data, o_last, o_word_idx
   );
endinterface

// File: rtl/mx_block_packer.sv
// Captures one MX block (scale exponent plus k elements) and streams it out as bus_width-bit words.
// Optional MX_PACK_NAN_FLUSH_EN: a block whose scale exponent is 0xFF is stored with all element bits zeroed.
module mx_block_packer #(
   parameter int exp_width = 3,
   parameter int man_width = 2,
   parameter int bit_width = 1 + exp_width + man_width,
   parameter int k         = 32,
   parameter int bus_width = 32
) (
   input logic              i_clk,
   input logic              i_rst,
   mx_block_packer_if.slave bus
);
   localparam int blk_bits = 8 + k * bit_width;
   localparam int n_words  = (blk_bits + bus_width - 1) / bus_width;
   localparam int buf_bits = n_words * bus_width;
   localparam int cnt_w    = (n_words > 1) ? $clog2(n_words) : 1;

   typedef enum logic {IDLE, SEND} state_t;

   state_t                state_q, state_d;
   logic [buf_bits-1:0]   shreg_p1;
   logic [cnt_w-1:0]      cnt_p1;
   logic                  load, shift, accept, last;

   // Exponent in the low byte, element i above it, zero padding to a whole number of words.
   function automatic logic [buf_bits-1:0] pack_block(
      input logic [7:0]                  exp,
      input logic [k-1:0][bit_width-1:0] vec
   );
      logic [buf_bits-1:0] p;
      p      = '0;
      p[7:0] = exp;
      for (int i = 0; i < k; i++) begin
`ifdef MX_PACK_NAN_FLUSH_EN
         p[8 + i*bit_width +: bit_width] = (exp == 8'hFF) ? '0 : vec[i];
`else
         p[8 + i*bit_width +: bit_width] = vec[i];
`endif
      end
      return p;
   endfunction

   assign last          = (cnt_p1 == cnt_w'(n_words - 1));
   // A new block may enter on the same cycle the final word of the current one leaves.
   assign bus.o_ready   = !i_rst && (state_q == IDLE ||
                                     (state_q == SEND && bus.i_ready && last));
   assign accept        = bus.i_valid && bus.o_ready;
   assign bus.o_valid   = (state_q == SEND);
   assign bus.o_data    = shreg_p1[bus_width-1:0];
   assign bus.o_last    = last && bus.o_valid;
   assign bus.o_word_idx = cnt_p1;

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      shift   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               load    = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            if (bus.i_ready) begin
               if (!last)       shift   = 1'b1;
               else if (accept) load    = 1'b1;
               else             state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Stage p1: word buffer and word counter
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= IDLE;
         cnt_p1   <= '0;
         shreg_p1 <= '0;
      end else begin
         state_q <= state_d;
         if (load) begin
            shreg_p1 <= pack_block(bus.i_mx_exp, bus.i_mx_vec);
            cnt_p1   <= '0;
         end else if (shift) begin
            shreg_p1 <= shreg_p1 >> bus_width;
            cnt_p1   <= cnt_p1 + cnt_w'(1);
         end
      end
   end
endmodule

// File: tb/tb_mx_block_packer.sv
// Randomised and directed bench for mx_block_packer against a word-queue reference model.
module tb_mx_block_packer;
   localparam int EXPW = 3;
   localparam int MANW = 2;
   localparam int BITW = 1 + EXPW + MANW;
   localparam int K    = 32;
   localparam int BUSW = 32;
   localparam int BLKB = 8 + K * BITW;
   localparam int NW   = (BLKB + BUSW - 1) / BUSW;

   typedef struct {
      logic [BUSW-1:0] d;
      int              idx;
      logic            last;
   } word_t;

   logic i_clk = 1'b0;
   logic i_rst = 1'b1;
   int   passed = 0;
   int   total  = 0;
   word_t q[$];
   int   run_len = 0;
   int   max_run = 0;
   logic [BUSW-1:0] w0_seen = '0;
   logic rand_ready = 1'b0;
   logic [BITW-1:0] el [K];

   always #5 i_clk = ~i_clk;

   mx_block_packer_if #(.bit_width(BITW), .k(K), .bus_width(BUSW)) bus ();

   mx_block_packer #(.exp_width(EXPW), .man_width(MANW), .k(K), .bus_width(BUSW)) dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .bus   (bus)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   // Word j read straight off the documented block layout, bit by bit.
   function automatic logic [BUSW-1:0] model_word(input int j, input logic [7:0] e,
                                                  input logic [K-1:0][BITW-1:0] v);
      logic [BUSW-1:0] w;
      logic            nan;
      int              g;
      w = '0;
`ifdef MX_PACK_NAN_FLUSH_EN
      nan = (e == 8'hFF);
`else
      nan = 1'b0;
`endif
      for (int b = 0; b < BUSW; b++) begin
         g = j * BUSW + b;
         if (g < 8)         w[b] = e[g];
         else if (g < BLKB) w[b] = nan ? 1'b0 : v[(g-8)/BITW][(g-8)%BITW];
         else               w[b] = 1'b0;
      end
      return w;
   endfunction

   always @(negedge i_clk) begin
      if (i_rst) begin
         q.delete();
         run_len = 0;
         check_val("rst_valid", bus.o_valid, 0);
         check_val("rst_ready", bus.o_ready, 0);
         check_val("rst_data", bus.o_data, 0);
         check_val("rst_last", bus.o_last, 0);
         check_val("rst_idx", bus.o_word_idx, 0);
      end else begin
         check_val("valid", bus.o_valid, q.size() != 0);
         check_val("ready", bus.o_ready, (q.size() == 0) || (q.size() == 1 && bus.i_ready));
         if (bus.o_valid) run_len++; else run_len = 0;
         if (run_len > max_run) max_run = run_len;
         if (bus.o_valid && q.size() != 0) begin
            check_val("data", bus.o_data, q[0].d);
            check_val("idx", bus.o_word_idx, q[0].idx);
            check_val("last", bus.o_last, q[0].last);
            if (bus.i_ready) begin
               if (q[0].idx == 0) w0_seen = bus.o_data;
               void'(q.pop_front());
            end
         end
         if (bus.i_valid && bus.o_ready)
            for (int j = 0; j < NW; j++)
               q.push_back('{d: model_word(j, bus.i_mx_exp, bus.i_mx_vec), idx: j, last: (j == NW-1)});
      end
   end

   always @(posedge i_clk) begin
      if (rand_ready) begin
         #1;
         bus.i_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Called at posedge+1; returns at posedge+1 just after the block was taken.
   task automatic send_block(input logic [7:0] e);
      bit ok = 0;
      bus.i_mx_exp = e;
      for (int i = 0; i < K; i++) bus.i_mx_vec[i] = el[i];
      bus.i_valid = 1'b1;
      for (int c = 0; c < 300; c++) begin
         @(negedge i_clk);
         if (bus.o_ready) begin ok = 1; break; end
      end
      if (!ok) check_val("send_timeout", 0, 1);
      @(posedge i_clk); #1;
      bus.i_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok = 0;
      for (int c = 0; c < 500; c++) begin
         @(negedge i_clk);
         if (q.size() == 0 && !bus.o_valid) begin ok = 1; break; end
      end
      if (!ok) check_val("drain_timeout", 0, 1);
      @(posedge i_clk); #1;
   endtask

   task automatic wait_idx(input int idx);
      bit ok = 0;
      for (int c = 0; c < 50; c++) begin
         if (bus.o_valid && bus.o_word_idx == idx) begin ok = 1; break; end
         @(posedge i_clk); #1;
      end
      if (!ok) check_val("idx_timeout", 0, 1);
   endtask

   initial begin
      bus.i_valid  = 1'b0;
      bus.i_ready  = 1'b1;
      bus.i_mx_exp = '0;
      bus.i_mx_vec = '0;
      repeat (3) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(posedge i_clk); #1;

      // All-ones elements with a small exponent
      for (int i = 0; i < K; i++) el[i] = 6'h3F;
      send_block(8'h7A);
      drain();
      check_val("t1_word0", w0_seen, 32'hFFFFFF7A);

      for (int i = 0; i < K; i++) el[i] = '0;
      el[0] = 6'h01;
      send_block(8'h00);
      drain();
      check_val("t2_word0", w0_seen, 32'h00000100);

      // Back-to-back blocks must leave no gap in o_valid
      max_run = 0;
      for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
      send_block(8'h11);
      for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
      send_block(8'h22);
      drain();
      check_val("b2b_run", max_run, 2 * NW);

      // Backpressure while word 3 is presented
      for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
      send_block(8'h33);
      wait_idx(3);
      bus.i_ready = 1'b0;
      repeat (5) begin
         @(negedge i_clk);
         check_val("bp_idx", bus.o_word_idx, 3);
         check_val("bp_ready", bus.o_ready, 0);
      end
      @(posedge i_clk); #1;
      bus.i_ready = 1'b1;
      drain();

      // Reset in the middle of a block
      for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
      send_block(8'h44);
      wait_idx(4);
      i_rst = 1'b1;
      #1;
      check_val("mid_rst_valid", bus.o_valid, 0);
      check_val("mid_rst_idx", bus.o_word_idx, 0);
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check_val("post_rst_ready", bus.o_ready, 1);
      @(posedge i_clk); #1;
      for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
      send_block(8'h55);
      drain();

      // NaN scale exponent
      for (int i = 0; i < K; i++) el[i] = 6'h15;
      send_block(8'hFF);
      drain();
`ifdef MX_PACK_NAN_FLUSH_EN
      check_val("nan_word0", w0_seen, 32'h000000FF);
`else
      check_val("nan_word0", w0_seen, 32'h555555FF);
`endif

      // Random blocks, gaps and downstream stalls
      rand_ready = 1'b1;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < K; i++) el[i] = BITW'($urandom);
         send_block(($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom));
         repeat ($urandom_range(0, 2)) begin @(posedge i_clk); #1; end
      end
      rand_ready = 1'b0;
      @(posedge i_clk); #2;
      bus.i_ready = 1'b1;
      drain();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
